// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREGS register file with two writeback ports, a per-register
// busy (scoreboard) bit set on issue and cleared on writeback, and a registered
// count of pending registers. Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// to the read ports (and mask the busy flag for a forwarded source).
module regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic [AW:0]     pending_cnt
);

  localparam logic [AW:0] CntOne = (AW+1)'(1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Next state: writes (wb1 wins), busy set/clear (issue wins), incremental count.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wb1_en && wb1_addr == AW'(i)) begin
        regs_d[i] = wb1_data;
      end else if (wb0_en && wb0_addr == AW'(i)) begin
        regs_d[i] = wb0_data;
      end
      if (issue_valid && issue_rd == AW'(i)) begin
        busy_d[i] = 1'b1;
      end else if ((wb0_en && wb0_addr == AW'(i)) || (wb1_en && wb1_addr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      // Each bit contributes at most once, so a same-address double clear counts once.
      if (busy_d[i] && !busy_q[i]) begin
        cnt_d = cnt_d + CntOne;
      end else if (!busy_d[i] && busy_q[i]) begin
        cnt_d = cnt_d - CntOne;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Combinational read ports; register 0 stays zero and never busy.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so outputs read zero immediately.
    if (reset_n && rs1_addr != '0) begin
      if (wb1_en && wb1_addr == rs1_addr) begin
        rs1_data = wb1_data;
        rs1_busy = 1'b0;
      end else if (wb0_en && wb0_addr == rs1_addr) begin
        rs1_data = wb0_data;
        rs1_busy = 1'b0;
      end
    end
    if (reset_n && rs2_addr != '0) begin
      if (wb1_en && wb1_addr == rs2_addr) begin
        rs2_data = wb1_data;
        rs2_busy = 1'b0;
      end else if (wb0_en && wb0_addr == rs2_addr) begin
        rs2_data = wb0_data;
        rs2_busy = 1'b0;
      end
    end
`endif
  end

  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected values are queued when stimulus is
// driven and popped against DUT outputs at the check points.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  logic            clk;
  logic            reset_n;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            wb0_en, wb1_en;
  logic [AW-1:0]   wb0_addr, wb1_addr;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic [AW:0]     pending_cnt;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb0_en      (wb0_en),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb1_en      (wb1_en),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h required=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    wb0_en      = 1'b0;
    wb1_en      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    issue_rd = '0; wb0_addr = '0; wb1_addr = '0;
    wb0_data = '0; wb1_data = '0;
    idle();
    #3;
    push("reset_cnt", 32'd0);    chk(32'(pending_cnt));
    push("reset_rs1", 32'd0);    chk(rs1_data);
    push("reset_busy", 32'd0);   chk(32'(rs1_busy));
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // x5 <= DEADBEEF via wb0, write to x0 via wb1 ignored
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    wb1_en = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h12345678;
    push("x5_write", 32'hDEADBEEF);
    push("x0_zero", 32'd0);
    step(); idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
    chk(rs1_data);
    chk(rs2_data);

    // same-address double write: wb1 wins
    wb0_en = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h2;
    push("x7_wb1_wins", 32'h2);
    step(); idle();
    rs1_addr = 5'd7; #1;
    chk(rs1_data);

    // issue x3 then x4, then clear both in one cycle
    issue_valid = 1'b1; issue_rd = 5'd3; step();
    issue_rd = 5'd4; step(); idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4; #1;
    push("cnt_two", 32'd2);      chk(32'(pending_cnt));
    push("x3_busy", 32'd1);      chk(32'(rs1_busy));
    push("x4_busy", 32'd1);      chk(32'(rs2_busy));
    wb0_en = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h33;
    wb1_en = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h44;
    step(); idle(); #1;
    push("cnt_dual_clear", 32'd0); chk(32'(pending_cnt));
    push("x3_free", 32'd0);        chk(32'(rs1_busy));
    push("x4_data", 32'h44);       chk(rs2_data);

    // x9 busy, then issue + writeback to x9 same cycle: set wins
    issue_valid = 1'b1; issue_rd = 5'd9; step(); idle();
    rs1_addr = 5'd9; #1;
    push("x9_cnt", 32'd1);       chk(32'(pending_cnt));
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    step(); idle(); #1;
    push("x9_data", 32'h99);     chk(rs1_data);
    push("x9_busy_kept", 32'd1); chk(32'(rs1_busy));
    push("x9_cnt_same", 32'd1);  chk(32'(pending_cnt));

    // x13 busy, both ports clear it: net -1
    issue_valid = 1'b1; issue_rd = 5'd13; step(); idle(); #1;
    push("x13_cnt", 32'd2);      chk(32'(pending_cnt));
    wb0_en = 1'b1; wb0_addr = 5'd13; wb0_data = 32'hA;
    wb1_en = 1'b1; wb1_addr = 5'd13; wb1_data = 32'hB;
    step(); idle(); #1;
    push("x13_same_clear", 32'd1); chk(32'(pending_cnt));

    // writeback to non-busy x6 leaves count alone; then make x6 busy
    wb0_en = 1'b1; wb0_addr = 5'd6; wb0_data = 32'h1111;
    step(); idle(); #1;
    push("x6_nonbusy_cnt", 32'd1); chk(32'(pending_cnt));
    issue_valid = 1'b1; issue_rd = 5'd6; step(); idle();
    rs1_addr = 5'd6; #1;
    push("x6_cnt", 32'd2);       chk(32'(pending_cnt));
    wb0_en = 1'b1; wb0_addr = 5'd6; wb0_data = 32'hCAFE; #1;
`ifdef REGFILE_BYPASS_EN
    push("x6_fwd_data", 32'hCAFE); push("x6_fwd_busy", 32'd0);
`else
    push("x6_old_data", 32'h1111); push("x6_old_busy", 32'd1);
`endif
    chk(rs1_data);
    chk(32'(rs1_busy));
    step(); idle(); #1;
    push("x6_after_data", 32'hCAFE); chk(rs1_data);
    push("x6_after_busy", 32'd0);    chk(32'(rs1_busy));
    push("x6_after_cnt", 32'd1);     chk(32'(pending_cnt));

    // three busy registers, then async reset mid-cycle with activity pending
    issue_valid = 1'b1; issue_rd = 5'd10; step();
    issue_rd = 5'd11; step(); idle(); #1;
    push("three_busy", 32'd3);   chk(32'(pending_cnt));
    issue_valid = 1'b1; issue_rd = 5'd12;
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h5555;
    rs1_addr = 5'd5; rs2_addr = 5'd9;
    #1 reset_n = 1'b0;
    #1;
    push("rst_cnt", 32'd0);      chk(32'(pending_cnt));
    push("rst_rs1", 32'd0);      chk(rs1_data);
    push("rst_rs2_busy", 32'd0); chk(32'(rs2_busy));
    push("rst_rs2", 32'd0);      chk(rs2_data);
    step(); idle();
    @(negedge clk);
    reset_n = 1'b1;
    step(); #1;
    push("post_rst_cnt", 32'd0); chk(32'(pending_cnt));
    push("post_rst_x5", 32'd0);  chk(rs1_data);

    // normal operation resumes
    wb1_en = 1'b1; wb1_addr = 5'd1; wb1_data = 32'hA5;
    issue_valid = 1'b1; issue_rd = 5'd2;
    step(); idle();
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    push("resume_x1", 32'hA5);   chk(rs1_data);
    push("resume_x2", 32'd1);    chk(32'(rs2_busy));
    push("resume_cnt", 32'd1);   chk(32'(pending_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL take parameter XLEN, default 32, data width in bits.
REQ-002 SHALL take parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rs1_addr, rs2_addr  input  AW  read addresses.
REQ-006 SHALL have ports rs1_data, rs2_data  output  XLEN  combinational read data.
REQ-007 SHALL have ports rs1_busy, rs2_busy  output  1  source register has a pending write.
REQ-008 SHALL have ports issue_valid  input  1, and issue_rd  input  AW; together they mark a register pending.
REQ-009 SHALL have ports wb0_en, wb1_en  input  1; wb0_addr, wb1_addr  input  AW; wb0_data, wb1_data  input  XLEN; these are the two writeback ports.
REQ-010 SHALL have port pending_cnt  output  AW+1  registered count of busy registers.

Function
REQ-011 SHALL write wbN_data into regs[wbN_addr] at a rising clk when wbN_en=1 and wbN_addr!=0.
REQ-012 SHALL resolve same-cycle wb0/wb1 writes to the same address in favour of wb1, for both the data and the forwarded value.
REQ-013 SHALL hold register 0 at zero: reads return 0, rsN_busy=0, and writes and issues to it are ignored.
REQ-014 SHALL keep a busy bit per register.
- REQ-014a: the busy bit is set at the clk edge when issue_valid=1 and issue_rd!=0.
- REQ-014b: the busy bit is cleared at the clk edge when any enabled writeback targets that register.
REQ-015 SHALL leave the busy bit set when an issue and a writeback target the same register in the same cycle (the set wins).
REQ-016 SHALL drive rsN_busy combinationally from the busy bit, qualified per REQ-025/026.
REQ-017 SHALL update pending_cnt one cycle after the edge to equal the popcount of the busy bits.
- It is maintained incrementally: +1 on a set of a non-busy bit, -1 per cleared busy bit.
- It never wraps; its range is 0..NREGS-1.
REQ-018 SHALL apply a writeback to a non-busy register as a normal write, with no change to the busy bit or pending_cnt.
REQ-019 SHALL decrement pending_cnt by 1 for each distinct busy register cleared when wb0 and wb1 both clear in one cycle (net -2 for distinct addresses, -1 for the same address).
REQ-020 SHALL have zero-cycle read latency; rsN_data depends only on the register state and, per REQ-025, the current writeback inputs.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously clear all registers, all busy bits and pending_cnt to 0.
REQ-022 SHALL, on an assertion of reset_n mid-operation, discard any same-cycle issue or writeback.
REQ-023 SHALL, while reset_n=0 or immediately after it, drive rs1_data=rs2_data=0, rs1_busy=rs2_busy=0 and pending_cnt=0.
REQ-024 SHALL resume normal operation at the first rising clk after reset_n deasserts.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle writeback data:
- rsN_data returns wbN_data (wb1 priority) when an enabled writeback matches rsN_addr!=0;
- rsN_busy is forced low in that case.
REQ-026 SHALL, with REGFILE_BYPASS_EN undefined, return the stored value and the un-cleared busy bit until the edge after the write; no forwarding logic is present.

Verification
REQ-027 The bench SHALL cover: reset, then wb0 writes 0xDEADBEEF to x5, wb1 writes 0x12345678 to x0 -> next cycle x5=0xDEADBEEF, x0 reads 0.
REQ-028 The bench SHALL cover: wb0 and wb1 both write x7, with 0x1 and 0x2 -> x7=0x2.
REQ-029 The bench SHALL cover: issue x3, then x4 -> pending_cnt=2, rs1_busy=1 at x3; then wb0 to x3 and wb1 to x4 in one cycle -> pending_cnt=0.
REQ-030 The bench SHALL cover: x9 busy, then issue x9 and wb0 to x9 in the same cycle -> x9 data updated, busy stays 1, pending_cnt unchanged.
REQ-031 The bench SHALL cover: rs1_addr=6 with wb0 writing 0xCAFE to x6 in the same cycle -> rs1_data=0xCAFE and rs1_busy=0 with REGFILE_BYPASS_EN; the old value and the old busy bit without it.
REQ-032 The bench SHALL cover: reset_n pulsed low mid-stream with 3 busy registers -> all data 0, busy 0 and pending_cnt 0 immediately, before any clk edge.
